cnn_layer_sequencer: RTL and testbench
======================================

# cnn_layer_sequencer

Parametrised frame controller for the CNN core. It drives up to NUM_LAYERS compute layers (conv, pool, FC, ...) in a fixed order using one-cycle start pulses and done handshakes. Layers can be bypassed per frame through a run-time mask. The block adds a per-layer watchdog timeout, abort, continuous (back-to-back frame) mode and a frame cycle counter, and returns the last executed layer's scalar result to the core's top level.

## Interface
- NUM_LAYERS, 3: number of sequenced layers (1..16).
- DATA_W, 32: width of the result path.
- TMO_W, 16: width of the watchdog limit and counter.
- CYC_W, 24: width of the frame cycle counter.
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- enable  input  1  frame request; sampled in IDLE and DONE only.
- abort  input  1  synchronous abort, highest priority after reset.
- continuous  input  1  auto-restart a new frame after each DONE.
- layer_mask  input  NUM_LAYERS  bit i=1 runs layer i; sampled once at frame start.
- timeout_limit  input  TMO_W  maximum WAIT cycles per layer; 0 disables the watchdog.
- layer_done  input  NUM_LAYERS  done pulse or level from each layer.
- result_in  input  DATA_W signed  result bus of the final executed layer.
- layer_start  output  NUM_LAYERS  one-hot, one-cycle start pulse.
- value  output  DATA_W signed  frame result.
- done  output  1  frame complete; held high while in DONE.
- busy  output  1  high in START and WAIT.
- error  output  1  held high in ERROR.
- err_layer  output  4  index of the layer that timed out.
- cur_layer  output  4  index of the active layer.
- frame_cycles  output  CYC_W  cycle count of the last completed frame.

## Operation
- States: IDLE, START, WAIT, DONE, ERROR.
- Reset (rst_n low, async): state=IDLE, all outputs 0, mask latch 0, timer 0, internal cycle counter 0.
- Priority each cycle: rst_n, then abort, then normal transitions. Abort in any state goes to IDLE next cycle. It clears layer_start, busy, done, error and the timer. value, frame_cycles and err_layer are kept.
- IDLE or DONE with enable=1:
  - Latch layer_mask.
  - If the latched mask is 0: go to ERROR with err_layer=4'hF.
  - Otherwise go to START with cur_layer = lowest set bit and the internal cycle counter cleared to 0.
  - Leaving DONE drops done.
- DONE with continuous=1 behaves exactly as if enable=1.
- START lasts exactly 1 cycle:
  - layer_start[cur_layer]=1 and all other bits 0.
  - Clear the timer and go to WAIT.
  - layer_done is ignored in this cycle.
- WAIT, on layer_done[cur_layer]=1:
  - If a higher set mask bit exists: cur_layer = next higher set bit, go to START.
  - Otherwise: value <= result_in, frame_cycles <= counter+1, go to DONE.
- WAIT, other behaviour:
  - layer_done bits of non-current layers are ignored in all states.
  - Timer increments each WAIT cycle without done.
  - If timeout_limit≠0 and timer==timeout_limit-1 with no done: go to ERROR, err_layer=cur_layer.
  - Done and timeout in the same cycle: done wins.
- ERROR: error=1, busy=0. It is left only by abort (to IDLE) or reset. enable is ignored.
- The internal counter increments in START and WAIT. It saturates at all-ones; saturation is not an error.
- A mid-frame change of layer_mask has no effect until the next frame start.

## Timing
- layer_start, done, busy, error, cur_layer and value are registered; there is no combinational input-to-output path.
- enable high at edge N: layer_start[first] high in cycle N+1, busy high from N+1.
- A layer done sampled at edge M gives the next layer_start in cycle M+1. Overhead is 1 cycle per layer transition.
- Last done at edge M gives done=1 and a valid value from cycle M+1.
- frame_cycles = total START+WAIT cycles. With k enabled layers each taking d_i WAIT cycles, frame_cycles = k + Σd_i, where d_i counts the done cycle.
- Continuous mode: DONE is held for exactly 1 cycle, then the next frame's layer_start follows in the next cycle.
- Watchdog: with timeout_limit=T and no done, ERROR is entered at the edge ending the T-th WAIT cycle.

## Test plan
- Basic 3-layer run: mask=3'b111, layer i answers 4/6/2 cycles after its start, result_in=32'hFFFF_FFF9.
  - Starts are seen on bits 0, 1, 2 in turn.
  - done=1 and value=-7.
  - frame_cycles=3+12=15.
- Layer bypass: mask=3'b101.
  - layer_start[1] never pulses; layer 2 starts 1 cycle after layer 0's done.
  - A stray layer_done[1] during the frame has no effect.
- Watchdog: timeout_limit=5, layer 1 never responds.
  - error=1 and err_layer=1 exactly 5 cycles after entering WAIT; busy=0.
  - enable is ignored; abort returns to IDLE with error=0.
  - A second case with done and the timeout in the same cycle must advance normally.
- Continuous mode: continuous=1, two frames.
  - done is high exactly 1 cycle, and the second layer_start[0] follows in the next cycle.
  - value updates per frame.
  - A mask change mid-frame takes effect only in frame 2.
- Empty mask and abort/reset:
  - mask=0 with enable gives ERROR with err_layer=4'hF.
  - abort mid-WAIT gives IDLE next cycle with value kept.
  - rst_n low mid-frame clears every output asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/cnn_layer_sequencer_if.sv
// rtl/cnn_layer_sequencer_if.sv - layer handshake bus between the sequencer and its compute layers
//
// Purpose: bundles the per-layer start pulses, done returns and the shared
//          result bus of the executing layer.
// Signals:
//   layer_start  one-hot, one-cycle start pulse per layer (sequencer -> layers)
//   layer_done   done pulse or level from each layer     (layers -> sequencer)
//   result_in    signed scalar result of the layer that finished last
// Modports: master = sequencer side, slave = layer side.
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 3,
  parameter int DATA_W     = 32
);
  logic [NUM_LAYERS-1:0]    layer_start;
  logic [NUM_LAYERS-1:0]    layer_done;
  logic signed [DATA_W-1:0] result_in;

  modport master (
    output layer_start,
    input  layer_done,
    input  result_in
  );

  modport slave (
    input  layer_start,
    output layer_done,
    output result_in
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - frame controller sequencing up to NUM_LAYERS CNN layers
//
// Purpose: runs the unmasked layers of a frame in ascending index order with
//          one-cycle start pulses and done handshakes, with per-layer watchdog,
//          abort, back-to-back frame mode and a frame cycle counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          frame request (looked at in IDLE and DONE)
//   abort           synchronous abort back to IDLE
//   continuous      restart a new frame straight out of DONE
//   layer_mask      per-layer run mask, latched at frame start
//   timeout_limit   max WAIT cycles per layer, 0 disables the watchdog
//   lyr             layer handshake bus (master side)
//   value           result of the last executed layer of the last frame
//   done/busy/error status flags
//   err_layer       layer that timed out (4'hF for an empty mask)
//   cur_layer       active layer index
//   frame_cycles    START+WAIT cycles of the last completed frame
module cnn_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int DATA_W     = 32,
  parameter int TMO_W      = 16,
  parameter int CYC_W      = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic [NUM_LAYERS-1:0]    layer_mask,
  input  logic [TMO_W-1:0]         timeout_limit,
  cnn_layer_sequencer_if.master    lyr,
  output logic signed [DATA_W-1:0] value,
  output logic                     done,
  output logic                     busy,
  output logic                     error,
  output logic [3:0]               err_layer,
  output logic [3:0]               cur_layer,
  output logic [CYC_W-1:0]         frame_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_LAYERS-1:0]    mask_q, mask_d;
  logic [3:0]               cur_q, cur_d;
  logic [3:0]               err_q, err_d;
  logic [TMO_W-1:0]         timer_q, timer_d;
  logic [CYC_W-1:0]         cyc_q, cyc_d, cyc_inc;
  logic signed [DATA_W-1:0] value_q, value_d;
  logic [CYC_W-1:0]         frame_q, frame_d;
  logic [NUM_LAYERS-1:0]    start_d;

  logic [3:0]               lo_bit, nx_bit;
  logic                     lo_found, nx_found;
  logic [NUM_LAYERS-1:0]    cur_oh;
  logic                     cur_done;

  // Bit scans: lowest set bit of the incoming mask (frame start) and the next
  // set bit above the current layer in the latched mask.
  always_comb begin
    lo_bit   = 4'd0;
    lo_found = 1'b0;
    nx_bit   = 4'd0;
    nx_found = 1'b0;
    cur_oh   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_mask[i]) begin
        lo_bit   = 4'(i);
        lo_found = 1'b1;
      end
      if (mask_q[i] && (i > int'(cur_q))) begin
        nx_bit   = 4'(i);
        nx_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cur_oh[i] = (int'(cur_q) == i);
    end
  end

  // Only the active layer's done matters; all other done bits are masked off.
  assign cur_done = |(lyr.layer_done & cur_oh);
  assign cyc_inc  = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    err_d   = err_q;
    timer_d = timer_q;
    cyc_d   = cyc_q;
    value_d = value_q;
    frame_d = frame_q;
    if (abort) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (enable || (state_q == S_DONE && continuous)) begin
            mask_d = layer_mask;
            if (!lo_found) begin
              state_d = S_ERROR;
              err_d   = 4'hF;
            end else begin
              state_d = S_START;
              cur_d   = lo_bit;
              cyc_d   = '0;
            end
          end
        end
        S_START: begin
          timer_d = '0;
          cyc_d   = cyc_inc;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          cyc_d = cyc_inc;
          if (cur_done) begin
            if (nx_found) begin
              cur_d   = nx_bit;
              state_d = S_START;
            end else begin
              value_d = lyr.result_in;
              frame_d = cyc_inc;
              state_d = S_DONE;
            end
          end else if (timeout_limit != '0 &&
                       timer_q == timeout_limit - TMO_W'(1)) begin
            state_d = S_ERROR;
            err_d   = cur_q;
          end else begin
            timer_d = timer_q + TMO_W'(1);
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    start_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      start_d[i] = (state_d == S_START) && (int'(cur_d) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      mask_q          <= '0;
      cur_q           <= '0;
      err_q           <= '0;
      timer_q         <= '0;
      cyc_q           <= '0;
      value_q         <= '0;
      frame_q         <= '0;
      lyr.layer_start <= '0;
      done            <= 1'b0;
      busy            <= 1'b0;
      error           <= 1'b0;
    end else begin
      state_q         <= state_d;
      mask_q          <= mask_d;
      cur_q           <= cur_d;
      err_q           <= err_d;
      timer_q         <= timer_d;
      cyc_q           <= cyc_d;
      value_q         <= value_d;
      frame_q         <= frame_d;
      lyr.layer_start <= start_d;
      done            <= (state_d == S_DONE);
      busy            <= (state_d == S_START) || (state_d == S_WAIT);
      error           <= (state_d == S_ERROR);
    end
  end

  assign value        = value_q;
  assign err_layer    = err_q;
  assign cur_layer    = cur_q;
  assign frame_cycles = frame_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - directed self-checking bench for cnn_layer_sequencer
module tb_cnn_layer_sequencer;
  localparam int NL = 3;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int CW = 24;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic                 abort;
  logic                 continuous;
  logic [NL-1:0]        layer_mask;
  logic [TW-1:0]        timeout_limit;
  logic signed [DW-1:0] value;
  logic                 done;
  logic                 busy;
  logic                 error;
  logic [3:0]           err_layer;
  logic [3:0]           cur_layer;
  logic [CW-1:0]        frame_cycles;

  cnn_layer_sequencer_if #(.NUM_LAYERS(NL), .DATA_W(DW)) lyr ();

  cnn_layer_sequencer #(
    .NUM_LAYERS(NL), .DATA_W(DW), .TMO_W(TW), .CYC_W(CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .abort         (abort),
    .continuous    (continuous),
    .layer_mask    (layer_mask),
    .timeout_limit (timeout_limit),
    .lyr           (lyr),
    .value         (value),
    .done          (done),
    .busy          (busy),
    .error         (error),
    .err_layer     (err_layer),
    .cur_layer     (cur_layer),
    .frame_cycles  (frame_cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int dly [NL];
  logic [NL-1:0] extra;
  logic [NL-1:0] start_q [$];
  int            start_cyc [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Layer model: layer i raises done d_i WAIT cycles after its start pulse
  // (d_i = 0 means it never answers); also logs every start pulse.
  initial begin
    int cnt [NL];
    logic [NL-1:0] nd;
    lyr.layer_done = '0;
    for (int i = 0; i < NL; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      nd = '0;
      for (int i = 0; i < NL; i++) begin
        if (!rst_n) cnt[i] = 0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) nd[i] = 1'b1;
        end
        if (lyr.layer_start[i]) cnt[i] = dly[i];
      end
      lyr.layer_done = nd | extra;
      if (lyr.layer_start != '0) begin
        start_q.push_back(lyr.layer_start);
        start_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_end(input string tag, input int max);
    int n = 0;
    while (!done && !error && n < max) begin
      tick();
      n++;
    end
    check({tag, "_bound"}, 64'(done | error), 64'd1);
  endtask

  task automatic clear_log();
    start_q.delete();
    start_cyc.delete();
  endtask

  task automatic kick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    abort         = 1'b0;
    continuous    = 1'b0;
    layer_mask    = '0;
    timeout_limit = '0;
    lyr.result_in = '0;
    extra         = '0;
    dly           = '{0, 0, 0};
    repeat (2) tick();

    check("rst_start", 64'(lyr.layer_start), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_value", 64'($unsigned(value)), 64'd0);
    check("rst_frame", 64'(frame_cycles), 64'd0);
    check("rst_err_layer", 64'(err_layer), 64'd0);
    check("rst_cur_layer", 64'(cur_layer), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic three-layer frame
    dly           = '{4, 6, 2};
    lyr.result_in = 32'hFFFF_FFF9;
    layer_mask    = 3'b111;
    clear_log();
    kick();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_first_start", 64'(lyr.layer_start), 64'b001);
    wait_end("t1", 40);
    check("t1_done", 64'(done), 64'd1);
    check("t1_error", 64'(error), 64'd0);
    check("t1_value", 64'($unsigned(value)), 64'hFFFF_FFF9);
    check("t1_frame", 64'(frame_cycles), 64'd15);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_nstarts", 64'(start_q.size()), 64'd3);
    if (start_q.size() == 3) begin
      check("t1_start0", 64'(start_q[0]), 64'b001);
      check("t1_start1", 64'(start_q[1]), 64'b010);
      check("t1_start2", 64'(start_q[2]), 64'b100);
      check("t1_gap01", 64'(start_cyc[1] - start_cyc[0]), 64'd5);
      check("t1_gap12", 64'(start_cyc[2] - start_cyc[1]), 64'd7);
    end
    tick();
    check("t1_done_hold", 64'(done), 64'd1);

    // Bypass layer 1, with a stray done from it mid-frame
    dly           = '{3, 0, 2};
    lyr.result_in = 32'd1234;
    layer_mask    = 3'b101;
    clear_log();
    kick();
    check("t2_first_start", 64'(lyr.layer_start), 64'b001);
    tick();
    extra = 3'b010;
    tick();
    extra = 3'b000;
    check("t2_stray_cur", 64'(cur_layer), 64'd0);
    check("t2_stray_busy", 64'(busy), 64'd1);
    wait_end("t2", 40);
    check("t2_done", 64'(done), 64'd1);
    check("t2_value", 64'($unsigned(value)), 64'd1234);
    check("t2_frame", 64'(frame_cycles), 64'd7);
    check("t2_nstarts", 64'(start_q.size()), 64'd2);
    if (start_q.size() == 2) begin
      check("t2_start0", 64'(start_q[0]), 64'b001);
      check("t2_start1", 64'(start_q[1]), 64'b100);
      check("t2_gap", 64'(start_cyc[1] - start_cyc[0]), 64'd4);
    end

    // Watchdog on layer 1
    timeout_limit = 16'd5;
    dly           = '{2, 0, 0};
    layer_mask    = 3'b111;
    clear_log();
    kick();
    wait_end("t3", 40);
    check("t3_error", 64'(error), 64'd1);
    check("t3_err_layer", 64'(err_layer), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_done", 64'(done), 64'd0);
    check("t3_nstarts", 64'(start_q.size()), 64'd2);
    if (start_q.size() == 2) begin
      check("t3_latency", 64'(cyc - start_cyc[1]), 64'd6);
    end
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    check("t3_enable_ignored", 64'(error), 64'd1);
    check("t3_no_start", 64'(lyr.layer_start), 64'd0);
    do_abort();
    check("t3_abort_error", 64'(error), 64'd0);
    check("t3_abort_busy", 64'(busy), 64'd0);
    check("t3_keep_err_layer", 64'(err_layer), 64'd1);
    check("t3_keep_value", 64'($unsigned(value)), 64'd1234);

    // Done and timeout in the same cycle: done wins
    timeout_limit = 16'd4;
    dly           = '{4, 0, 0};
    layer_mask    = 3'b001;
    lyr.result_in = 32'd7;
    kick();
    wait_end("t3b", 40);
    check("t3b_done", 64'(done), 64'd1);
    check("t3b_error", 64'(error), 64'd0);
    check("t3b_frame", 64'(frame_cycles), 64'd5);
    check("t3b_value", 64'($unsigned(value)), 64'd7);
    do_abort();

    // Continuous mode, mask changed during frame 1
    timeout_limit = '0;
    dly           = '{2, 3, 1};
    layer_mask    = 3'b011;
    continuous    = 1'b1;
    lyr.result_in = 32'd100;
    clear_log();
    kick();
    check("t4_first_start", 64'(lyr.layer_start), 64'b001);
    layer_mask = 3'b100;
    wait_end("t4a", 40);
    check("t4_done1", 64'(done), 64'd1);
    check("t4_value1", 64'($unsigned(value)), 64'd100);
    check("t4_frame1", 64'(frame_cycles), 64'd7);
    tick();
    check("t4_done_pulse", 64'(done), 64'd0);
    check("t4_restart", 64'(lyr.layer_start), 64'b100);
    lyr.result_in = 32'd200;
    continuous    = 1'b0;
    wait_end("t4b", 40);
    check("t4_value2", 64'($unsigned(value)), 64'd200);
    check("t4_frame2", 64'(frame_cycles), 64'd2);
    check("t4_nstarts", 64'(start_q.size()), 64'd3);
    if (start_q.size() == 3) begin
      check("t4_f1_layer1", 64'(start_q[1]), 64'b010);
      check("t4_f2_start", 64'(start_q[2]), 64'b100);
      check("t4_f2_gap", 64'(start_cyc[2] - start_cyc[1]), 64'd5);
    end
    tick();
    check("t4_done_hold", 64'(done), 64'd1);

    // Empty mask
    layer_mask = 3'b000;
    kick();
    check("t5_error", 64'(error), 64'd1);
    check("t5_err_layer", 64'(err_layer), 64'hF);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    do_abort();

    // Abort mid-WAIT
    dly           = '{0, 0, 0};
    layer_mask    = 3'b001;
    lyr.result_in = 32'd999;
    kick();
    repeat (3) tick();
    check("t6_busy_wait", 64'(busy), 64'd1);
    do_abort();
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_error", 64'(error), 64'd0);
    check("t6_value_kept", 64'($unsigned(value)), 64'd200);
    check("t6_frame_kept", 64'(frame_cycles), 64'd2);

    // Asynchronous reset in the middle of a start pulse
    layer_mask = 3'b010;
    kick();
    check("t7_start", 64'(lyr.layer_start), 64'b010);
    check("t7_cur", 64'(cur_layer), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_start_rst", 64'(lyr.layer_start), 64'd0);
    check("t7_busy_rst", 64'(busy), 64'd0);
    check("t7_cur_rst", 64'(cur_layer), 64'd0);
    check("t7_value_rst", 64'($unsigned(value)), 64'd0);
    check("t7_frame_rst", 64'(frame_cycles), 64'd0);
    check("t7_err_layer_rst", 64'(err_layer), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
